mux2_rr_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 2:1 select datapath between two requesters (port 0, port 1).
- Drives the mux select, gates transfers to a single downstream valid/ready channel, and holds the grant for a whole packet.
- A beat limit forces rotation so one requester cannot starve the other.
- Sits between two stream sources and any single-consumer sink.

---
 rtl/mux2_rr_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter steering a shared 2:1 datapath onto one valid/ready sink.
// Define MUX2_ARB_STATS_EN to add saturating per-port transfer counters.
module mux2_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              last0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic              last1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
`ifdef MUX2_ARB_STATS_EN
    ,
    output logic [15:0]       xfer_cnt0,
    output logic [15:0]       xfer_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] HOLD = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       gnt0_q, gnt1_q;
    logic       xfer;

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign sel  = gnt0_q;

    // Owner's request drives valid; the mux follows the registered select.
    always_comb begin
        out_valid = 1'b0;
        unique case (state_q)
            OWN0:    out_valid = req0;
            OWN1:    out_valid = req1;
            default: out_valid = 1'b0;
        endcase
        out_data = gnt0_q ? data0 : data1;
        out_last = gnt0_q ? last0 : last1;
        xfer     = out_valid && out_ready;
    end

    // Arbitration, grant-end detection and handover to the other port.
    always_comb begin
        logic   own0;
        logic   cur_req;
        logic   oth_req;
        logic   grant_end;
        logic [7:0] cnt_inc;
        state_t other;

        state_d    = state_q;
        prio_d     = prio_q;
        beat_cnt_d = beat_cnt_q;
        own0       = (state_q == OWN0);
        cur_req    = own0 ? req0 : req1;
        oth_req    = own0 ? req1 : req0;
        other      = own0 ? OWN1 : OWN0;
        cnt_inc    = beat_cnt_q + 8'd1;
        grant_end  = 1'b0;

        if (state_q == IDLE) begin
            if (req0 && req1)
                state_d = prio_q ? OWN1 : OWN0;
            else if (req0)
                state_d = OWN0;
            else if (req1)
                state_d = OWN1;
        end else begin
            grant_end = !cur_req ||
                        (xfer && (out_last || cnt_inc == HOLD));
            if (grant_end) begin
                prio_d     = own0;
                beat_cnt_d = 8'd0;
                state_d    = oth_req ? other : IDLE;
            end else if (xfer) begin
                beat_cnt_d = cnt_inc;
            end
        end
    end

    // State, priority, beat counter and registered grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            beat_cnt_q <= 8'd0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            beat_cnt_q <= beat_cnt_d;
            gnt0_q     <= (state_d == OWN0);
            gnt1_q     <= (state_d == OWN1);
        end
    end

`ifdef MUX2_ARB_STATS_EN
    // Saturating count of completed transfers per port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt0 <= 16'd0;
            xfer_cnt1 <= 16'd0;
        end else begin
            if (xfer && gnt0_q && xfer_cnt0 != 16'hFFFF)
                xfer_cnt0 <= xfer_cnt0 + 16'd1;
            if (xfer && gnt1_q && xfer_cnt1 != 16'hFFFF)
                xfer_cnt1 <= xfer_cnt1 + 16'd1;
        end
    end
`endif

endmodule
